seq_divider: RTL and testbench
==============================

# seq_divider

Multicycle 32-bit integer divider that acts as the responder on the CPU's `div_start`/`div_ready` handshake. It captures the dividend and divisor on an accepted start, runs a radix-2 restoring division over WIDTH cycles, and returns the quotient on `lo` and the remainder on `hi`. A zero divisor is flagged through `div_zero` so the control unit can raise the exception. It sits beside the multiplier in the datapath, and its `hi`/`lo` outputs feed the HI/LO registers.

## Interface
- WIDTH, 32, operand, quotient and remainder width; iteration count equals WIDTH.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  dividend, captured on the accepting edge.
- b  in  WIDTH  divisor, captured on the accepting edge.
- unsigned_op  in  1  present only with DIVU_EN; selects unsigned division; captured with a and b.
- hi  out  WIDTH  remainder, registered.
- lo  out  WIDTH  quotient, registered.
- ready  out  1  one-cycle completion pulse.
- div_zero  out  1  divisor was zero; high only together with ready.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, RUN, FIXUP, DONE.
- IDLE, start=1: capture a, b (and unsigned_op), then go to SETUP. With start=0, stay in IDLE.
- SETUP, b==0: go to DONE with div_zero set. Do not change hi or lo.
- SETUP, b!=0: compute the magnitudes |a| and |b| (plain values when unsigned). Record the quotient sign as sign(a) XOR sign(b) and the remainder sign as sign(a). Clear the partial remainder, clear the iteration counter, then go to RUN.
- RUN, each iteration:
  - Shift the partial remainder left one bit, bringing in the dividend MSB.
  - Compute a trial subtraction of |b| using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and shift a 1 into the quotient; otherwise restore and shift a 0.
  - After WIDTH iterations (counter at WIDTH-1), go to FIXUP.
- FIXUP: negate the quotient if its sign bit is set, and negate the remainder if its sign bit is set. Load hi and lo, then go to DONE.
- DONE: assert ready, with div_zero if flagged. Return to IDLE. A start in DONE is ignored.
- Signed results follow MIPS div rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0 with no flag.
- A start while busy is ignored. A held start begins a new operation on the first IDLE cycle.
- Reset values: hi=0, lo=0, ready=0, div_zero=0, busy=0, state IDLE.
- Reset mid-operation aborts the division. No ready pulse is produced, and all outputs return to their reset values on the next edge.

## Timing
- Number cycles from the accepting edge: cycle 1 is SETUP.
- Normal operation: RUN occupies cycles 2..WIDTH+1, FIXUP is cycle WIDTH+2, DONE is cycle WIDTH+3. For WIDTH=32, ready is high in cycle 35.
- Divide by zero: DONE is cycle 2, with ready=1 and div_zero=1 in that cycle.
- hi and lo change only on the FIXUP→DONE edge. They are stable during the ready cycle and hold until the next successful completion.
- Minimum spacing between accepted starts: WIDTH+4 cycles for a normal division, 3 cycles for divide by zero.
- busy rises in cycle 1 and falls after the DONE cycle.

## Configuration
- DIVU_EN defined: adds the unsigned_op port. When unsigned_op=1, operands are treated as unsigned, sign fix-up is skipped, and timing is identical to a signed division.
- DIVU_EN undefined: no unsigned_op port and every operation is signed. No logic for unsigned selection is generated.

## Structure
- Package div_pkg holds:
  - the state enum: IDLE, SETUP, RUN, FIXUP, DONE;
  - the default DIV_WIDTH=32;
  - the counter width, $clog2(DIV_WIDTH).
- Sub-module div_sign_fix is the combinational conditional two's-complement negator. It is instantiated for operand magnitudes in SETUP and for results in FIXUP.
- The FSM, counter, partial remainder and quotient shift registers stay in seq_divider.

## Test plan
- Basic signed division: a=100, b=7 → ready in cycle 35, lo=14, hi=2, div_zero=0.
- Negative dividend: a=0xFFFFFF9C (-100), b=7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- Divide by zero, run after the first test: b=0 → ready with div_zero=1 in cycle 2; hi=2 and lo=14 are unchanged; a following start is accepted.
- Overflow case: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Reset and start handling:
  - Assert reset in cycle 10 of an operation → no ready pulse, and hi, lo and busy read 0.
  - Pulse start in cycle 20 of an operation → it is ignored, and only one ready pulse appears, in cycle 35.
- With DIVU_EN, unsigned_op=1: a=0xFFFFFF9C, b=7 → lo=0x24924916, hi=2.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state encoding, default operand width and iteration counter width.
// Build option DIVU_EN (consumed by seq_divider_if / seq_divider) adds unsigned division.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// CPU <-> divider request/response bundle.
// Master is the control unit issuing start; slave is seq_divider answering with ready.
// DIVU_EN adds the unsigned_op request bit.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef DIVU_EN
    logic             unsigned_op;
`endif
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             div_zero;
    logic             busy;

`ifdef DIVU_EN
    modport master (output start, a, b, unsigned_op,
                    input  hi, lo, ready, div_zero, busy);
    modport slave  (input  start, a, b, unsigned_op,
                    output hi, lo, ready, div_zero, busy);
`else
    modport master (output start, a, b,
                    input  hi, lo, ready, div_zero, busy);
    modport slave  (input  start, a, b,
                    output hi, lo, ready, div_zero, busy);
`endif

endinterface

// File: rtl/seq_divider_sign_fix.sv
// Conditional two's-complement negator (magnitude extraction and result sign fix-up).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // The most negative value maps to itself, which is exactly what the
    // overflow case (MIN / -1) needs on the quotient path.
    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: lo = quotient, hi = remainder; DIVU_EN adds unsigned_op.
// Latency: ready in cycle WIDTH+3 after the accepting edge, cycle 2 for a zero divisor.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

    div_state_t       state, next_state;
    logic [WIDTH-1:0] a_q;        // dividend, shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0] b_q;        // divisor, then its magnitude
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             zero_flag;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             signed_op;

`ifdef DIVU_EN
    logic             uns_q;
    assign signed_op = ~uns_q;
`else
    assign signed_op = 1'b1;
`endif

    logic             a_sgn, b_sgn, in_setup;
    logic [WIDTH-1:0] fix0_out, fix1_in, fix1_out;
    logic             fix0_neg, fix1_neg;
    logic [WIDTH:0]   trial;
    logic             sub_ok;

    assign a_sgn    = signed_op & a_q[WIDTH-1];
    assign b_sgn    = signed_op & b_q[WIDTH-1];
    assign in_setup = (state == SETUP);

    // Two negators shared between SETUP (operand magnitudes) and FIXUP (results).
    assign fix0_neg = in_setup ? a_sgn : q_neg;
    assign fix1_in  = in_setup ? b_q   : rem_q;
    assign fix1_neg = in_setup ? b_sgn : r_neg;

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.din(a_q),     .neg(fix0_neg), .dout(fix0_out));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.din(fix1_in), .neg(fix1_neg), .dout(fix1_out));

    // WIDTH+1-bit trial subtract; a non-negative result always fits in WIDTH bits.
    assign trial  = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    assign sub_ok = ~trial[WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state   = state;
        bus.ready    = 1'b0;
        bus.div_zero = 1'b0;
        bus.busy     = (state != IDLE);
        unique case (state)
            IDLE:    if (bus.start) next_state = SETUP;
            SETUP:   next_state = (b_q == '0) ? DONE : RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE: begin
                bus.ready    = 1'b1;
                bus.div_zero = zero_flag;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_flag <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef DIVU_EN
            uns_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    a_q       <= bus.a;
                    b_q       <= bus.b;
                    zero_flag <= 1'b0;
`ifdef DIVU_EN
                    uns_q     <= bus.unsigned_op;
`endif
                end
                SETUP: begin
                    if (b_q == '0) begin
                        zero_flag <= 1'b1;
                    end else begin
                        a_q   <= fix0_out;
                        b_q   <= fix1_out;
                        q_neg <= a_sgn ^ b_sgn;
                        r_neg <= a_sgn;
                        rem_q <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    rem_q <= sub_ok ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
                    a_q   <= {a_q[WIDTH-2:0], sub_ok};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    lo_q <= fix0_out;
                    hi_q <= fix1_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with a queue-based scoreboard.
// Stimulus pushes expected {lo, hi, div_zero, ready cycle}; a monitor pops on every ready.
// DIVU_EN, when defined, also exercises the unsigned path.
module tb_seq_divider;
    import div_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready at cycle count %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, ".lo"},       bus.lo, e.lo);
                chk({e.name, ".hi"},       bus.hi, e.hi);
                chk({e.name, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, e.dz});
                chk({e.name, ".cycle"},    cyc, e.cyc);
            end
        end
    end

    // Drive a request from IDLE; returns the cycle count seen just after the accepting edge.
    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic uns,
                         input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edz, input string name, output int acc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
`ifdef DIVU_EN
        bus.unsigned_op = uns;
`else
        if (uns) $display("note: unsigned request issued in a signed-only build");
`endif
        @(posedge clk);
        #1;
        acc       = cyc;
        bus.start = 1'b0;
        if (push) sbq.push_back('{elo, ehi, edz, acc + (edz ? 1 : 34), name});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b expected 0 within 100 cycles", bus.busy);
        end
    endtask

    initial begin
        int acc;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef DIVU_EN
        bus.unsigned_op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.hi",       bus.hi, 32'd0);
        chk("reset.lo",       bus.lo, 32'd0);
        chk("reset.ready",    {31'd0, bus.ready}, 32'd0);
        chk("reset.div_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("reset.busy",     {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        // 100 / 7 = 14 r 2
        issue(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, "pos_div", acc);
        @(negedge clk);
        chk("busy_cycle1", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        // Zero divisor leaves hi/lo alone; start held high is taken on the first IDLE cycle.
        issue(32'd123, 32'd0, 1'b0, 1, 32'd14, 32'd2, 1'b1, "div_by_zero", acc);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FF9C;
        bus.b     = 32'd7;
        sbq.push_back('{32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, acc + 3 + 34, "neg_dividend_held"});
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();

        // MIN / -1 wraps to MIN with zero remainder and no flag.
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'h8000_0000, 32'd0, 1'b0, "overflow", acc);
        wait_idle();
        issue(32'd7, 32'hFFFF_FFFE, 1'b0, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, "pos_by_neg", acc);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1, 32'd3, 32'hFFFF_FFFF, 1'b0, "neg_by_neg", acc);
        wait_idle();
        issue(32'd5, 32'd10, 1'b0, 1, 32'd0, 32'd5, 1'b0, "small_by_big", acc);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 32'd0, 32'hFFFF_FFFF, 1'b0, "m1_by_min", acc);
        wait_idle();

        // A start pulse in cycle 20 must be ignored: one ready only, from the first request.
        issue(32'd1000, 32'd3, 1'b0, 1, 32'd333, 32'd1, 1'b0, "ignore_start", acc);
        repeat (19) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Reset during cycle 10 aborts: no ready, outputs cleared.
        issue(32'd77, 32'd5, 1'b0, 0, 32'd0, 32'd0, 1'b0, "aborted", acc);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.hi",    bus.hi, 32'd0);
        chk("abort.lo",    bus.lo, 32'd0);
        chk("abort.busy",  {31'd0, bus.busy}, 32'd0);
        chk("abort.ready", {31'd0, bus.ready}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

`ifdef DIVU_EN
        issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1, 32'h2492_4916, 32'd2, 1'b0, "unsigned_div", acc);
        wait_idle();
        issue(32'hFFFF_FF9C, 32'd7, 1'b0, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "signed_sel", acc);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
